n_bit_adder_display: RTL
========================

N_BIT_ADDER_DISPLAY -- requirements
Module: n_bit_adder_display

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL satisfy 1 <= WIDTH and WIDTH+1 <= 4*DIGITS.
REQ-002 Parameter DIGITS, default 4, number of multiplexed seven-segment digits, range 1..8.
REQ-003 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz), minimum 2.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 clr_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 blank  input  1  1 = leading-zero blanking enabled.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry out (subtract: 1 = no borrow).
REQ-012 ovf  output  1  registered signed overflow.
REQ-013 an  output  DIGITS  digit enables, active-low, one-hot-low.
REQ-014 ca  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-015 dp  output  1  decimal point, active-low.

Function
REQ-016 Stage 1 SHALL register a, b, sub every clock, with no enable.
REQ-017 Stage 2 SHALL compute {cout,sum} = a + (b XOR {WIDTH{sub}}) + sub from stage-1 registers and register the result: latency 2 cycles from input to sum/cout/ovf.
REQ-018 ovf SHALL be 1 when the stage-1 operand MSBs, after the B inversion, are equal and the sum MSB differs from them.
REQ-019 Display value SHALL be {cout,sum}, zero-extended to 4*DIGITS bits; nibble k drives digit k, with digit 0 the rightmost.
REQ-020 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; at terminal count the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-021 The display value SHALL be snapshotted into a shadow register only when the digit index wraps to 0, so one scan never mixes two results.
REQ-022 an, ca and dp SHALL be registered and reflect the current digit index and snapshot one cycle after the index changes.
REQ-023 Hex encoding 0..F SHALL be: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (7-bit hex, active-low).
REQ-024 With blank=1, a digit k>0 whose snapshot nibbles k..DIGITS-1 are all zero SHALL have an[k]=1 during its slot; digit 0 is never blanked.
REQ-025 dp SHALL be 0 only during the digit-0 slot when the snapshot ovf bit is 1; otherwise dp SHALL be 1.
REQ-026 Operand changes SHALL NOT disturb the refresh counter or the digit index.

Reset
REQ-027 While clr_n=0: all pipeline registers, sum, cout, ovf, snapshot, refresh counter and digit index SHALL be 0; an SHALL be all ones, ca 7'h7F and dp 1.
REQ-028 Reset asserted mid-scan SHALL take effect immediately, without waiting for a clock.
REQ-029 On the first clock after clr_n rises, an SHALL enable digit 0 showing snapshot 0 (ca=7'h40).

Verification
REQ-030 Bench SHALL use WIDTH=4, DIGITS=4, REFRESH_DIV=4 and cover:
REQ-031 Reset pulse mid-scan -> an=4'hF, ca=7'h7F, dp=1 and sum=0 asynchronously; after release, the first edge gives an=4'b1110.
REQ-032 a=1, b=2, sub=0 -> two cycles later sum=3, cout=0, ovf=0; after the next snapshot the digit-0 slot shows ca=7'h30 and digit 1 shows 7'h40 (blank=0).
REQ-033 a=F, b=1, sub=0 -> sum=0, cout=1; display 0x10, digit 1 shows 7'h79 and digit 0 shows 7'h40; with blank=1, an[3:2] stay 1 for the whole scan.
REQ-034 a=3, b=5, sub=1 -> sum=E, cout=0, ovf=0; a=8, b=1, sub=1 -> sum=7, cout=1, ovf=1, and dp=0 only in the digit-0 slot.
REQ-035 Operands changed mid-scan -> digits of the current scan keep the old snapshot and the new value appears only after the index wraps to 0; an is one-hot-low every cycle after reset.

Source files
------------

// File: rtl/n_bit_adder_display.sv
// Two-stage pipelined add/subtract unit with a multiplexed seven-segment
// hex display of {cout, sum} and an overflow marker on the digit-0 point.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// cnt         | cycles spent in the current digit slot, 0..REFRESH_DIV-1
// idx         | digit currently being driven, 0..DIGITS-1 (0 = rightmost)
// snap        | display value latched at the start of each scan

module n_bit_adder_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sub,
    input  logic              blank,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        ca,
    output logic              dp
);

    localparam int NIBW = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNTW = $clog2(REFRESH_DIV);

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sub_q;

    logic [WIDTH-1:0]  b_x;
    logic [WIDTH:0]    full;
    logic              ovf_nxt;

    logic [CNTW-1:0]   cnt;
    logic [IDXW-1:0]   idx;
    logic              cnt_tc;
    logic              idx_tc;
    logic [NIBW-1:0]   disp_val;
    logic [NIBW-1:0]   snap;
    logic              snap_ovf;

    logic [NIBW-1:0]   shifted;
    logic [3:0]        nib;
    logic              dig_blank;
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        ca_nxt;
    logic              dp_nxt;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Stage 1: capture operands and mode every cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
        end
    end

    // Subtraction is A + ~B + 1; overflow looks at the inverted B operand.
    always_comb begin
        b_x     = b_q ^ {WIDTH{sub_q}};
        full    = {1'b0, a_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_q};
        ovf_nxt = (a_q[WIDTH-1] == b_x[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Stage 2: register the arithmetic result.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            sum  <= full[WIDTH-1:0];
            cout <= full[WIDTH];
            ovf  <= ovf_nxt;
        end
    end

    always_comb begin
        disp_val = NIBW'({cout, sum});
        cnt_tc   = (cnt == CNTW'(REFRESH_DIV - 1));
        idx_tc   = (idx == IDXW'(DIGITS - 1));
    end

    // Slot timer and digit scan; the snapshot is taken only as the scan
    // restarts at digit 0 so one pass never shows two different results.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt      <= '0;
            idx      <= '0;
            snap     <= '0;
            snap_ovf <= 1'b0;
        end else if (cnt_tc) begin
            cnt <= '0;
            if (idx_tc) begin
                idx      <= '0;
                snap     <= disp_val;
                snap_ovf <= ovf;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A digit is blanked when it and every digit to its left are zero.
    always_comb begin
        shifted   = snap >> {idx, 2'b00};
        nib       = shifted[3:0];
        dig_blank = blank && (idx != '0) && (shifted == '0);
        an_nxt    = dig_blank ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx);
        ca_nxt    = dig_blank ? 7'h7F : hex_seg(nib);
        dp_nxt    = !((idx == '0) && snap_ovf);
    end

    // Registered display drive, one cycle behind the scan index.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an <= {DIGITS{1'b1}};
            ca <= 7'h7F;
            dp <= 1'b1;
        end else begin
            an <= an_nxt;
            ca <= ca_nxt;
            dp <= dp_nxt;
        end
    end

endmodule
